alu_bus_sequencer: RTL
======================

# alu_bus_sequencer

Control sequencer for the 4-bit register/ALU datapath: it accepts one command at a time and steps the shared 4-bit bus through operand reads, ALU execute and write-back. It drives the per-register write strobes, the tri-state buffer enables that put values on the bus, and the ALU operand latches and opcode. No data passes through it. It sits between the front-end FSM (switch/button command source) and the R/ALU/buff instances. It guarantees exactly one bus driver per cycle.

## Interface
- No parameters. Register count is fixed at 4 and the bus is 4 bits.
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  command request; sampled only in IDLE
- cmd_imm  in  1  1 = load-immediate (switch value via input buffer) into cmd_d; 0 = ALU command
- cmd_op  in  2  ALU opcode, passed through unchanged (00 add, 10 xor; 01/11 per ALU)
- cmd_a  in  2  index of the register read onto the bus for the left operand
- cmd_b  in  2  index of the register read onto the bus for the right operand
- cmd_d  in  2  index of the destination register
- busy  out  1  high while a command is in progress (execution states)
- done  out  1  one-cycle pulse after write-back
- reg_oe  out  4  one-hot output-buffer enables, registers 0..3 onto the bus
- reg_wr  out  4  one-hot register write strobes
- lat_l  out  1  ALU left-operand latch enable
- lat_r  out  1  ALU right-operand latch enable
- alu_op  out  2  opcode to ALU
- alu_oe  out  1  ALU result buffer enable onto the bus
- imm_oe  out  1  switch/immediate buffer enable onto the bus
- cmd_count  out  8  number of completed commands, modulo 256

## Operation
- States: IDLE, RD_A, RD_B, WB, IMM, DONE.
- IDLE, start=1 at an edge:
  - Capture cmd_imm, cmd_op, cmd_a, cmd_b and cmd_d.
  - Next state is IMM if cmd_imm=1, otherwise RD_A.
  - If start=0, stay in IDLE.
- RD_A: reg_oe[a]=1, lat_l=1. Next state RD_B.
- RD_B: reg_oe[b]=1, lat_r=1. Next state WB.
- WB: alu_oe=1, reg_wr[d]=1. Next state DONE.
- IMM: imm_oe=1, reg_wr[d]=1. Next state DONE.
- DONE: done=1; cmd_count increments (255 wraps to 0). Next state IDLE. start is ignored in DONE.
- busy=1 in RD_A, RD_B, WB and IMM; 0 in IDLE and DONE.
- alu_op equals the captured op in RD_A, RD_B and WB; 00 elsewhere.
- cmd_* and start are ignored in every state except IDLE. The captured copy is used throughout the command.
- Bus exclusivity: in every cycle, at most one of reg_oe[3:0], alu_oe and imm_oe is high. At most one reg_wr bit is high.
- a==b is legal (the same register is read twice). d==a or d==b is legal, because the write occurs after both reads.
- Outputs are Moore: decoded only from state and captured fields. There is no combinational path from any input to any output.

## Timing
- Reset (rst=0): asynchronous. State goes to IDLE and captured fields clear.
  - Every output is 0, including cmd_count=0.
  - If asserted mid-command, the command is discarded immediately and no further reg_wr is issued.
- After rst deasserts, the first start can be sampled at the next rising edge.
- Cycle numbering: edge 0 samples start.
- ALU command:
  - RD_A during cycle 1, RD_B cycle 2, WB cycle 3.
  - DONE cycle 4, with done=1 and cmd_count updated at the end of cycle 4.
  - Latency is 4 cycles from start to done.
  - The next start is sampled at edge 5, so throughput is one command per 5 cycles.
- Immediate command:
  - IMM during cycle 1, DONE cycle 2; latency 2.
  - The next start is sampled at edge 3.
- If start is held high continuously, a new command is accepted on every IDLE edge. No command is lost or duplicated.

## Test plan
- Reset: hold rst=0 with start=1 and random cmd_* → every output 0, cmd_count=0. Release rst → IDLE; first command accepted at the next edge.
- ADD a=1, b=2, d=3, op=00: start pulsed at edge 0 → expected outputs:
  - cycle 1: reg_oe=0010, lat_l=1
  - cycle 2: reg_oe=0100, lat_r=1
  - cycle 3: alu_oe=1, alu_op=00, reg_wr=1000
  - cycle 4: done=1, busy=0; cmd_count=1 afterward
- Immediate d=0: cmd_imm=1 → cycle 1: imm_oe=1, reg_wr=0001; cycle 2: done=1. Then XOR a=2, b=2, d=2, op=10 → cycle 1: reg_oe=0100; cycle 2: reg_oe=0100; cycle 3: reg_wr=0100, alu_op=10.
- start held high for 20 cycles while toggling cmd_* every cycle → commands accepted exactly at IDLE edges, each using the values captured there; cmd_count=4 after 20 cycles of ALU commands. The bus-exclusivity check passes every cycle.
- rst pulsed low during RD_B of an ADD with d=1 → outputs drop to 0 without waiting for an edge; reg_wr never goes high for that command; cmd_count is unchanged.
- Issue 256 immediate commands back-to-back → cmd_count wraps from 255 to 0 on the 256th done. Zero exclusivity or one-hot violations throughout.

Source files
------------

// File: rtl/alu_bus_sequencer.sv
// Command sequencer for the 4-register / ALU datapath: steps the shared 4-bit bus
// through operand reads, execute and write-back, one command at a time.
module alu_bus_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cmd_imm,
   input  logic [1:0] cmd_op,
   input  logic [1:0] cmd_a,
   input  logic [1:0] cmd_b,
   input  logic [1:0] cmd_d,
   output logic       busy,
   output logic       done,
   output logic [3:0] reg_oe,
   output logic [3:0] reg_wr,
   output logic       lat_l,
   output logic       lat_r,
   output logic [1:0] alu_op,
   output logic       alu_oe,
   output logic       imm_oe,
   output logic [7:0] cmd_count
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, WB, IMM, DONE} state_t;

   state_t     state, state_nx;
   logic [1:0] op_q, a_q, b_q, d_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         d_q       <= '0;
         cmd_count <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            op_q <= cmd_op;
            a_q  <= cmd_a;
            b_q  <= cmd_b;
            d_q  <= cmd_d;
         end
         if (state == DONE) cmd_count <= cmd_count + 8'd1;
      end
   end

   // Outputs decode only state and captured fields, so each state owns the bus alone.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      reg_oe   = '0;
      reg_wr   = '0;
      lat_l    = 1'b0;
      lat_r    = 1'b0;
      alu_op   = '0;
      alu_oe   = 1'b0;
      imm_oe   = 1'b0;
      case (state)
         IDLE: if (start) state_nx = cmd_imm ? IMM : RD_A;
         RD_A: begin
            busy        = 1'b1;
            reg_oe[a_q] = 1'b1;
            lat_l       = 1'b1;
            alu_op      = op_q;
            state_nx    = RD_B;
         end
         RD_B: begin
            busy        = 1'b1;
            reg_oe[b_q] = 1'b1;
            lat_r       = 1'b1;
            alu_op      = op_q;
            state_nx    = WB;
         end
         WB: begin
            busy        = 1'b1;
            alu_oe      = 1'b1;
            reg_wr[d_q] = 1'b1;
            alu_op      = op_q;
            state_nx    = DONE;
         end
         IMM: begin
            busy        = 1'b1;
            imm_oe      = 1'b1;
            reg_wr[d_q] = 1'b1;
            state_nx    = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
